// File: rtl/multi_rate_divider.sv
// Multi-channel rate divider: per-channel runtime divisor, periodic or
// one-shot mode, run control and a global Sync; all outputs registered.
//
// Ports:
//   ClockIn  rising-edge system clock
//   Resetn   asynchronous active-low reset
//   WrEn     configuration write strobe
//   WrChan   channel index to write (out-of-range writes are dropped)
//   WrDiv    divisor D (tick period D+1 cycles)
//   WrMode   0 = periodic, 1 = one-shot
//   Run      per-channel enable level
//   Sync     pulse restarting every counting channel
//   Tick     registered single-cycle enable pulses
//   Busy     channel is counting
//   Done     one-shot channel has fired and is holding
module multi_rate_divider #(
  parameter int NUM_CHANNELS = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int DEFAULT_DIV  = 500,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    ClockIn,
  input  logic                    Resetn,
  input  logic                    WrEn,
  input  logic [CW-1:0]           WrChan,
  input  logic [DIV_WIDTH-1:0]    WrDiv,
  input  logic                    WrMode,
  input  logic [NUM_CHANNELS-1:0] Run,
  input  logic                    Sync,
  output logic [NUM_CHANNELS-1:0] Tick,
  output logic [NUM_CHANNELS-1:0] Busy,
  output logic [NUM_CHANNELS-1:0] Done
);

  localparam longint MAX_DIV = (longint'(1) << DIV_WIDTH) - 1;

  if (DEFAULT_DIV < 0 || longint'(DEFAULT_DIV) > MAX_DIV) begin : g_bad_div
    $error("DEFAULT_DIV does not fit in DIV_WIDTH bits");
  end

  if (NUM_CHANNELS < 1) begin : g_bad_nc
    $error("NUM_CHANNELS must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } state_t;

  state_t                  r_state     [NUM_CHANNELS];
  state_t                  w_state_nxt [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0]    r_div       [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0]    r_cnt       [NUM_CHANNELS];
  logic [DIV_WIDTH-1:0]    w_cnt_nxt   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_mode;
  logic [NUM_CHANNELS-1:0] r_tick;
  logic [NUM_CHANNELS-1:0] w_tick_nxt;
  logic [NUM_CHANNELS-1:0] w_wr_hit;

  // An out-of-range WrChan matches no channel, so the write is dropped.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_wr_hit[c] = WrEn && (WrChan == CW'(c));
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_state_nxt[c] = r_state[c];
      w_cnt_nxt[c]   = r_cnt[c];
      w_tick_nxt[c]  = 1'b0;
      if (!Run[c]) begin
        w_state_nxt[c] = ST_IDLE;
        w_cnt_nxt[c]   = '0;
      end else begin
        case (r_state[c])
          ST_IDLE: begin
            w_state_nxt[c] = ST_COUNT;
            w_cnt_nxt[c]   = r_div[c];
          end
          ST_COUNT: begin
            // Sync wins over a coincident terminal count.
            if (Sync) begin
              w_cnt_nxt[c] = r_div[c];
            end else if (r_cnt[c] == '0) begin
              w_tick_nxt[c] = 1'b1;
              if (r_mode[c]) begin
                w_state_nxt[c] = ST_DONE;
              end else begin
                w_cnt_nxt[c] = r_div[c];
              end
            end else begin
              w_cnt_nxt[c] = r_cnt[c] - 1'b1;
            end
          end
          ST_DONE: begin
            w_state_nxt[c] = ST_DONE;
          end
          default: begin
            w_state_nxt[c] = ST_IDLE;
            w_cnt_nxt[c]   = '0;
          end
        endcase
      end
    end
  end

  // Loads above read the pre-edge r_div, so a coincident write lands later.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_state[c] <= ST_IDLE;
        r_cnt[c]   <= '0;
        r_div[c]   <= DIV_WIDTH'(DEFAULT_DIV);
      end
      r_mode <= '0;
      r_tick <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_state[c] <= w_state_nxt[c];
        r_cnt[c]   <= w_cnt_nxt[c];
        if (w_wr_hit[c]) begin
          r_div[c]  <= WrDiv;
          r_mode[c] <= WrMode;
        end
      end
      r_tick <= w_tick_nxt;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      Busy[c] = (r_state[c] == ST_COUNT);
      Done[c] = (r_state[c] == ST_DONE);
    end
  end

  assign Tick = r_tick;

endmodule

// File: tb/tb_multi_rate_divider.sv
// Bench for multi_rate_divider: directed steps plus random traffic,
// checked every cycle against a tick-schedule reference model.
module tb_multi_rate_divider;

  localparam int NC = 5;
  localparam int DW = 16;
  localparam int DD = 500;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [CW-1:0] wr_chan = '0;
  logic [DW-1:0] wr_div = '0;
  logic          wr_mode = 1'b0;
  logic [NC-1:0] run = '0;
  logic          sync = 1'b0;
  logic [NC-1:0] tick, busy, done;

  multi_rate_divider #(
    .NUM_CHANNELS(NC),
    .DIV_WIDTH   (DW),
    .DEFAULT_DIV (DD)
  ) dut (
    .ClockIn(clk),
    .Resetn (rst_n),
    .WrEn   (wr_en),
    .WrChan (wr_chan),
    .WrDiv  (wr_div),
    .WrMode (wr_mode),
    .Run    (run),
    .Sync   (sync),
    .Tick   (tick),
    .Busy   (busy),
    .Done   (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  // Model: each running channel knows the absolute edge of its next tick.
  int m_div  [NC];
  bit m_mode [NC];
  bit m_run  [NC];
  bit m_done [NC];
  bit m_tick [NC];
  int m_next [NC];

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_div[c]  = DD;
      m_mode[c] = 1'b0;
      m_run[c]  = 1'b0;
      m_done[c] = 1'b0;
      m_tick[c] = 1'b0;
      m_next[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    edge_n++;
    for (int c = 0; c < NC; c++) begin
      m_tick[c] = 1'b0;
      if (!run[c]) begin
        m_run[c]  = 1'b0;
        m_done[c] = 1'b0;
      end else if (!m_run[c]) begin
        m_run[c]  = 1'b1;
        m_done[c] = 1'b0;
        m_next[c] = edge_n + m_div[c] + 1;
      end else if (m_done[c]) begin
        m_tick[c] = 1'b0;
      end else if (sync) begin
        m_next[c] = edge_n + m_div[c] + 1;
      end else if (edge_n == m_next[c]) begin
        m_tick[c] = 1'b1;
        if (m_mode[c]) m_done[c] = 1'b1;
        else m_next[c] = edge_n + m_div[c] + 1;
      end
    end
    if (wr_en && int'(wr_chan) < NC) begin
      m_div[wr_chan]  = int'(wr_div);
      m_mode[wr_chan] = wr_mode;
    end
  endfunction

  function automatic logic [NC-1:0] e_tick();
    for (int c = 0; c < NC; c++) e_tick[c] = m_tick[c];
  endfunction

  function automatic logic [NC-1:0] e_busy();
    for (int c = 0; c < NC; c++) e_busy[c] = m_run[c] && !m_done[c];
  endfunction

  function automatic logic [NC-1:0] e_done();
    for (int c = 0; c < NC; c++) e_done[c] = m_done[c];
  endfunction

  task automatic chk(input string tag, input logic [NC-1:0] obs,
                     input logic [NC-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d obs=%b exp=%b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick", tick, e_tick());
    chk("busy", busy, e_busy());
    chk("done", done, e_done());
  endtask

  task automatic wr(input int ch, input int d, input bit m);
    wr_en   = 1'b1;
    wr_chan = CW'(ch);
    wr_div  = DW'(d);
    wr_mode = m;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int bound, output int k);
    k = 0;
    do begin
      cyc();
      k++;
    end while (!tick[ch] && k < bound);
  endtask

  int k;

  initial begin
    model_reset();
    #1;
    chk("rst_tick", tick, '0);
    chk("rst_busy", busy, '0);
    chk("rst_done", done, '0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // default divisor on ch0
    run[0] = 1'b1;
    cyc();
    wait_tick(0, 600, k);
    chk_int("first_tick_500", k, 501);
    wait_tick(0, 600, k);
    chk_int("period_500", k, 501);

    // D=0 periodic on ch1
    wr(1, 0, 1'b0);
    run[1] = 1'b1;
    repeat (6) cyc();
    chk_int("d0_tick_held", int'(tick[1]), 1);
    run[1] = 1'b0;
    cyc();
    chk_int("d0_stop", int'(tick[1]), 0);

    // one-shot ch2, restart, out-of-range write
    wr(2, 3, 1'b1);
    run[2] = 1'b1;
    cyc();
    wait_tick(2, 20, k);
    chk_int("oneshot_lat", k, 4);
    chk_int("oneshot_done", int'(done[2]), 1);
    repeat (8) cyc();
    run[2] = 1'b0;
    cyc();
    run[2] = 1'b1;
    cyc();
    wait_tick(2, 20, k);
    chk_int("oneshot_again", k, 4);
    wr(5, 0, 1'b0);
    wr(7, 1, 1'b1);
    repeat (6) cyc();

    // divisor change mid-count on ch0
    run[0] = 1'b0;
    cyc();
    wr(0, 4, 1'b0);
    run[0] = 1'b1;
    cyc();
    cyc();
    cyc();
    wr(0, 9, 1'b0);
    wait_tick(0, 20, k);
    chk_int("old_period_tail", k, 2);
    wait_tick(0, 20, k);
    chk_int("new_period", k, 10);

    // Sync with ch0 D=4 and ch1 D=9
    wr(0, 4, 1'b0);
    wr(1, 9, 1'b0);
    run[1] = 1'b1;
    repeat ($urandom_range(3, 20)) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    wait_tick(0, 20, k);
    chk_int("sync_ch0_a", k, 5);
    wait_tick(0, 20, k);
    chk_int("sync_ch0_b", k, 5);
    chk_int("sync_ch1", int'(tick[1]), 1);

    // Sync on ch0 terminal edge
    k = 0;
    while (m_next[0] != edge_n + 1 && k < 20) begin
      cyc();
      k++;
    end
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk_int("sync_suppress", int'(tick[0]), 0);
    repeat (12) cyc();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 29) == 0) run[c] = ~run[c];
      end
      sync = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        wr_en   = 1'b1;
        wr_chan = CW'($urandom_range(0, 7));
        wr_div  = DW'($urandom_range(0, 12));
        wr_mode = 1'($urandom_range(0, 1));
      end else begin
        wr_en = 1'b0;
      end
      cyc();
    end
    wr_en = 1'b0;
    sync  = 1'b0;

    // async reset while a tick is high
    run = '0;
    cyc();
    wr(0, 4, 1'b0);
    run[0] = 1'b1;
    wait_tick(0, 20, k);
    chk_int("pre_reset_tick", int'(tick[0]), 1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_tick", tick, '0);
    chk("arst_busy", busy, '0);
    chk("arst_done", done, '0);
    @(negedge clk);
    run   = '1;
    rst_n = 1'b1;
    cyc();
    wait_tick(0, 600, k);
    chk_int("reset_div_ch0", k, 501);
    chk_int("reset_div_ch4", int'(tick[4]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
